wg_stream_ctrl: RTL
===================

WG_STREAM_CTRL -- requirements
Module: wg_stream_ctrl

Interface
REQ-001 Parameter D_WL, default 24, bit width of one weight lane.
REQ-002 Parameter UNITS_NUM, default 5, lanes per weight word.
REQ-003 Parameter DEPTH, default 156, words per pass (max 256).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to stream one pass, sampled in IDLE only.
REQ-007 busy  output  1  high while the state is not IDLE.
REQ-008 done  output  1  one-cycle pulse after the final word transfers.
REQ-009 addr  output  8  weight-buffer read address, registered.
REQ-010 w_i  input  UNITS_NUM*D_WL  weight word from the buffer, combinational on addr.
REQ-011 w_o  output  UNITS_NUM*D_WL  weight word presented downstream.
REQ-012 w_valid  output  1  w_o, w_idx and w_last are valid.
REQ-013 w_ready  input  1  downstream accepts; a transfer is w_valid & w_ready at a rising edge.
REQ-014 w_idx  output  8  buffer index of the word on w_o.
REQ-015 w_last  output  1  w_o holds index DEPTH-1.

Function
REQ-016 FSM states are IDLE, FETCH, DRAIN and DONE.
REQ-017 IDLE->FETCH occurs on start=1; start in any other state has no effect.
REQ-018 FETCH captures {w_i, addr} into a 2-entry FIFO whenever entries<2 or a transfer pops this cycle, then increments addr.
REQ-019 Capturing at addr=DEPTH-1 moves the FSM FETCH->DRAIN and stops addr incrementing.
REQ-020 DRAIN->DONE occurs on the transfer of the index DEPTH-1 word; DONE->IDLE is unconditional after one cycle; done=1 only in DONE.
REQ-021 In IDLE and DONE, addr=0.
REQ-022 w_o, w_idx and w_last come from the FIFO head; w_valid = FIFO not empty.
REQ-023 Timing: start in cycle 0 gives addr=0 in cycle 1 and w_valid=1 with w_idx=0 in cycle 2.
REQ-024 With w_ready held high, throughput is one word per cycle with no bubbles, and w_idx=DEPTH-1 is presented in cycle DEPTH+1.
REQ-025 While w_valid=1 and w_ready=0, w_o, w_idx and w_last are held stable and no word is dropped or duplicated.
REQ-026 Fetching stalls only while the FIFO is full with no pop in progress.
REQ-027 Words are delivered in strictly increasing index order, 0..DEPTH-1, exactly once per pass.
REQ-028 w_o is a bit-exact copy of w_i at the captured addr, with no arithmetic on the data.

Reset
REQ-029 rst_n=0 immediately clears: state=IDLE, addr=0, FIFO empty, w_valid=0, w_last=0, w_idx=0, w_o=0, busy=0, done=0.
REQ-030 Reset during FETCH or DRAIN abandons the pass; after release, no stale word appears and a new start is required.

Configuration
REQ-031 When the macro WG_REPEAT_EN is defined, an input port repeat (1 bit) is added.
REQ-032 Under WG_REPEAT_EN, if repeat=1 when addr=DEPTH-1 is captured, addr wraps to 0 and the FSM stays in FETCH.
REQ-033 Under WG_REPEAT_EN, w_last still marks every index DEPTH-1 word, and done pulses only after a pass that ends with repeat=0.
REQ-034 When WG_REPEAT_EN is undefined, the repeat port is absent and every start produces exactly one pass.

Verification
REQ-035 Reset release, start in cycle 0, w_ready=1 -> w_valid first in cycle 2 (w_idx=0, w_o=buffer[0]); w_idx=155 with w_last=1 in cycle 157; done=1 in cycle 158; busy=0 in cycle 159.
REQ-036 w_ready=0 for cycles 2-9, then 1 -> addr stalls at 2 with FIFO full, w_o stays buffer[0] throughout, and all 156 words then arrive in order with no gaps.
REQ-037 Random w_ready at 30% duty -> scoreboard sees indices 0..155 exactly once each, w_o matches the buffer model, and w_last occurs only on index 155.
REQ-038 start pulsed again in cycle 50 of a pass -> ignored; exactly 156 transfers and a single done pulse.
REQ-039 rst_n=0 asserted in cycle 80 -> all outputs zero immediately; after release, w_valid stays 0 until the next start, and the next pass begins at index 0.
REQ-040 With WG_REPEAT_EN defined and repeat=1 for the first pass only -> 312 transfers, index 155 followed directly by index 0, w_last asserted twice, done asserted once at the end.

Source files
------------

// File: rtl/wg_stream_ctrl.sv
// Weight-buffer streaming controller: reads DEPTH words through a 2-entry skid FIFO onto a valid/ready stream.
// Optional macro WG_REPEAT_EN adds input repeat_pass to chain passes back to back.
module wg_stream_ctrl #(
   parameter int D_WL      = 24,
   parameter int UNITS_NUM = 5,
   parameter int DEPTH     = 156
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
`ifdef WG_REPEAT_EN
   input  logic                      repeat_pass,
`endif
   output logic                      busy,
   output logic                      done,
   output logic [7:0]                addr,
   input  logic [UNITS_NUM*D_WL-1:0] w_i,
   output logic [UNITS_NUM*D_WL-1:0] w_o,
   output logic                      w_valid,
   input  logic                      w_ready,
   output logic [7:0]                w_idx,
   output logic                      w_last,
   output logic [1:0]                dbg_state
);

   localparam int         W        = UNITS_NUM * D_WL;
   localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     addr_q, addr_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [W-1:0]   d0_q, d0_d, d1_q, d1_d;
   logic [7:0]     i0_q, i0_d, i1_q, i1_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           push, pop, rep;

`ifdef WG_REPEAT_EN
   assign rep = repeat_pass;
`else
   assign rep = 1'b0;
`endif

   // Stream handshake: a word moves when w_valid & w_ready are both high at a rising edge;
   // while w_valid is high and w_ready low, w_o/w_idx/w_last hold and w_valid stays high.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      i0_d    = i0_q;
      i1_d    = i1_q;
      pop     = (cnt_q != 2'd0) && w_ready;
      push    = (state_q == S_FETCH) && ((cnt_q != 2'd2) || pop);

      case ({push, pop})
         2'b01: begin
            d0_d  = d1_q;
            i0_d  = i1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b10: begin
            if (cnt_q == 2'd0) begin
               d0_d = w_i;
               i0_d = addr_q;
            end else begin
               d1_d = w_i;
               i1_d = addr_q;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b11: begin
            // Simultaneous pop and push keeps occupancy; the new word lands behind any survivor.
            if (cnt_q == 2'd1) begin
               d0_d = w_i;
               i0_d = addr_q;
            end else begin
               d0_d = d1_q;
               i0_d = i1_q;
               d1_d = w_i;
               i1_d = addr_q;
            end
         end
         default: ;
      endcase

      case (state_q)
         S_IDLE: begin
            addr_d = 8'd0;
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (push) begin
               if (addr_q == LAST_IDX) begin
                  if (rep) addr_d = 8'd0;
                  else     state_d = S_DRAIN;
               end else begin
                  addr_d = addr_q + 8'd1;
               end
            end
         end
         S_DRAIN: begin
            if (pop && (i0_q == LAST_IDX)) begin
               state_d = S_DONE;
               addr_d  = 8'd0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            addr_d  = 8'd0;
         end
         default: begin
            state_d = S_IDLE;
            addr_d  = 8'd0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= 8'd0;
         cnt_q   <= 2'd0;
         d0_q    <= '0;
         d1_q    <= '0;
         i0_q    <= 8'd0;
         i1_q    <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         i0_q    <= i0_d;
         i1_q    <= i1_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign addr      = addr_q;
   assign w_valid   = (cnt_q != 2'd0);
   assign w_o       = d0_q;
   assign w_idx     = i0_q;
   assign w_last    = w_valid && (i0_q == LAST_IDX);
   assign dbg_state = state_q;

endmodule
